// File: rtl/axi_ddr_responder_pkg.sv
// Shared types and constants for the AXI4 DDR-model responder: FSM state
// encoding, response codes and the fixed 16-byte beat geometry.
package axi_ddr_responder_pkg;

  localparam int BEAT_BYTES = 16;
  localparam int BEAT_BITS  = BEAT_BYTES * 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WDATA      = 3'd1,
    ST_WRESP      = 3'd2,
    ST_RADDR_WAIT = 3'd3,
    ST_RDATA      = 3'd4
  } state_t;

endpackage

// File: rtl/axi_ddr_bram.sv
// DEPTH x 128-bit storage with per-byte write enables and a registered
// (one-cycle) read port whose output holds while rd_en is low.
module axi_ddr_bram
  import axi_ddr_responder_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BEAT_BYTES-1:0]    wr_be,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [BEAT_BITS-1:0]     wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [BEAT_BITS-1:0]     rd_data
);

  logic [BEAT_BITS-1:0] mem_q [DEPTH];
  logic [BEAT_BITS-1:0] rd_data_d;
  logic [BEAT_BITS-1:0] rd_data_q;

  // NOTE: the array has no reset; contents must survive rst, and a reset
  // port would also prevent block-RAM inference.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BEAT_BYTES; b++) begin
      if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_ddr_responder.sv
// AXI4 slave that models DDR behind a single-outstanding FSM: round-robin
// AW/AR arbitration, strobed INCR writes, and no-bubble look-ahead reads.
module axi_ddr_responder
  import axi_ddr_responder_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
  input  logic [7:0]            S_AXI_AWLEN,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [BEAT_BITS-1:0]  S_AXI_WDATA,
  input  logic [BEAT_BYTES-1:0] S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [BEAT_BITS-1:0]  S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t               state_d, state_q;
  logic                 rd_pri_d, rd_pri_q;
  logic [IDX_W-1:0]     waddr_d, waddr_q;
  logic [IDX_W-1:0]     raddr_d, raddr_q;
  logic [7:0]           wcnt_d, wcnt_q;
  logic [7:0]           rcnt_d, rcnt_q;
  logic                 werr_d, werr_q;

  logic                 aw_grant, ar_grant;
  logic [BEAT_BYTES-1:0] ram_we;
  logic                 ram_re;
  logic [IDX_W-1:0]     ram_raddr;
  logic [BEAT_BITS-1:0] ram_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[3:0], S_AXI_AWADDR[ADDR_W-1:4+IDX_W],
                              S_AXI_ARADDR[3:0], S_AXI_ARADDR[ADDR_W-1:4+IDX_W]};

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_pri_d  = rd_pri_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    werr_d    = werr_q;
    aw_grant  = 1'b0;
    ar_grant  = 1'b0;
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_raddr = raddr_q;

    case (state_q)
      ST_IDLE: begin
        // Readies follow VALID combinationally, so they are masked in reset.
        if (rst) begin
          if (S_AXI_AWVALID && (!S_AXI_ARVALID || !rd_pri_q)) aw_grant = 1'b1;
          else if (S_AXI_ARVALID)                             ar_grant = 1'b1;
        end
        if (aw_grant) begin
          state_d  = ST_WDATA;
          waddr_d  = S_AXI_AWADDR[4 +: IDX_W];
          wcnt_d   = S_AXI_AWLEN;
          werr_d   = 1'b0;
          rd_pri_d = 1'b1;
        end else if (ar_grant) begin
          state_d  = ST_RADDR_WAIT;
          raddr_d  = S_AXI_ARADDR[4 +: IDX_W];
          rcnt_d   = S_AXI_ARLEN;
          rd_pri_d = 1'b0;
        end
      end

      ST_WDATA: begin
        if (S_AXI_WVALID) begin
          ram_we = S_AXI_WSTRB;
          // The beat count, not WLAST, ends the burst; WLAST only grades it.
          if (wcnt_q == 8'd0) begin
            werr_d  = werr_q | !S_AXI_WLAST;
            state_d = ST_WRESP;
          end else begin
            werr_d  = werr_q | S_AXI_WLAST;
            waddr_d = waddr_q + IDX_W'(1);
            wcnt_d  = wcnt_q - 8'd1;
          end
        end
      end

      ST_WRESP: begin
        if (S_AXI_BREADY) state_d = ST_IDLE;
      end

      ST_RADDR_WAIT: begin
        ram_re  = 1'b1;
        state_d = ST_RDATA;
      end

      ST_RDATA: begin
        if (S_AXI_RREADY) begin
          if (rcnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            // Fetch the next word now so it is on RDATA after this handshake.
            ram_re    = 1'b1;
            ram_raddr = raddr_q + IDX_W'(1);
            raddr_d   = raddr_q + IDX_W'(1);
            rcnt_d    = rcnt_q - 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rd_pri_q <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_pri_q <= rd_pri_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      werr_q   <= werr_d;
    end
  end

  axi_ddr_bram #(.DEPTH(DEPTH)) u_bram (
    .clk     (clk),
    .rst     (rst),
    .wr_be   (ram_we),
    .wr_addr (waddr_q),
    .wr_data (S_AXI_WDATA),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  assign S_AXI_AWREADY = aw_grant;
  assign S_AXI_ARREADY = ar_grant;
  assign S_AXI_WREADY  = (state_q == ST_WDATA);
  assign S_AXI_BVALID  = (state_q == ST_WRESP);
  assign S_AXI_BRESP   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RVALID  = (state_q == ST_RDATA);
  assign S_AXI_RLAST   = (state_q == ST_RDATA) && (rcnt_q == 8'd0);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = ram_rdata;

endmodule

// File: tb/tb_axi_ddr_responder.sv
// Self-checking bench for axi_ddr_responder: a word-array memory model with
// expected-beat queues, checked every cycle, plus literal spot checks.
module tb_axi_ddr_responder;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 27;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [ADDR_W-1:0]   AWADDR = '0;
  logic [7:0]          AWLEN = '0;
  logic                AWVALID = 1'b0, AWREADY;
  logic [127:0]        WDATA = '0;
  logic [15:0]         WSTRB = '0;
  logic                WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic [1:0]          BRESP;
  logic                BVALID, BREADY = 1'b0;
  logic [ADDR_W-1:0]   ARADDR = '0;
  logic [7:0]          ARLEN = '0;
  logic                ARVALID = 1'b0, ARREADY;
  logic [127:0]        RDATA;
  logic [1:0]          RRESP;
  logic                RLAST, RVALID, RREADY = 1'b0;

  always #5 clk = ~clk;

  axi_ddr_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST), .S_AXI_RVALID(RVALID),
    .S_AXI_RREADY(RREADY)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Behavioural model: word array, expected read beats and write responses.
  typedef struct {
    logic [127:0] data;
    logic         last;
  } rbeat_t;

  logic [127:0] model_mem [DEPTH];
  rbeat_t       exp_r[$];
  logic [1:0]   exp_b[$];
  logic [127:0] rd_log[$];
  logic         rl_log[$];
  logic [1:0]   b_log[$];
  int           grant_log[$];   // 1 = write granted, 0 = read granted
  int           w_beats = 0;
  int           cyc = 0;
  int           ar_cyc = 0;
  bit           lat_pending = 1'b0;

  logic [127:0] wd [16];
  logic [15:0]  ws [16];
  logic         wl [16];

  function automatic int widx(input logic [ADDR_W-1:0] a);
    return int'(a[ADDR_W-1:4]) % DEPTH;
  endfunction

  // Compare process: outputs are stable mid-cycle, inputs change just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (AWVALID && ARVALID) check("arb_single_grant", 128'(AWREADY && ARREADY), 128'(0));
      if (AWVALID && AWREADY) grant_log.push_back(1);
      if (ARVALID && ARREADY) begin
        grant_log.push_back(0);
        ar_cyc      = cyc;
        lat_pending = 1'b1;
      end
      if (WVALID && WREADY) w_beats++;
      if (RVALID) begin
        if (lat_pending) begin
          check("read_latency", 128'(cyc - ar_cyc), 128'(2));
          lat_pending = 1'b0;
        end
        if (exp_r.size() == 0) begin
          check("rvalid_without_burst", 128'(RVALID), 128'(0));
        end else begin
          check("rdata", RDATA, exp_r[0].data);
          check("rlast", 128'(RLAST), 128'(exp_r[0].last));
          check("rresp", 128'(RRESP), 128'(0));
          if (RREADY) begin
            rd_log.push_back(RDATA);
            rl_log.push_back(RLAST);
            void'(exp_r.pop_front());
          end
        end
      end
      if (BVALID) begin
        if (exp_b.size() == 0) begin
          check("bvalid_without_write", 128'(BVALID), 128'(0));
        end else begin
          check("bresp", 128'(BRESP), 128'(exp_b[0]));
          if (BREADY) begin
            b_log.push_back(BRESP);
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic write_burst(input logic [ADDR_W-1:0] addr, input int len);
    int  t;
    int  w = widx(addr);
    bit  err = 1'b0;
    for (int i = 0; i <= len; i++) err |= (wl[i] != (i == len));
    exp_b.push_back(err ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
    t = 0; @(negedge clk);
    while (!AWREADY && t < 100) begin @(negedge clk); t++; end
    if (!AWREADY) begin
      check("aw_handshake", 128'(AWREADY), 128'(1));
      AWVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = wl[i]; WVALID = 1'b1;
      t = 0; @(negedge clk);
      while (!WREADY && t < 100) begin @(negedge clk); t++; end
      if (!WREADY) begin
        check("w_handshake", 128'(WREADY), 128'(1));
        break;
      end
      for (int b = 0; b < 16; b++)
        if (ws[i][b]) model_mem[w][8*b +: 8] = wd[i][8*b +: 8];
      w = (w + 1) % DEPTH;
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    t = 0; @(negedge clk);
    while (!BVALID && t < 100) begin @(negedge clk); t++; end
    if (!BVALID) begin
      check("b_handshake", 128'(BVALID), 128'(1));
      return;
    end
    repeat (2) @(posedge clk);
    #1 BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] addr, input int len,
                            input int stall_beat, input int stall_cycles);
    int t;
    int w = widx(addr);
    @(posedge clk); #1;
    ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
    t = 0; @(negedge clk);
    while (!ARREADY && t < 100) begin @(negedge clk); t++; end
    if (!ARREADY) begin
      check("ar_handshake", 128'(ARREADY), 128'(1));
      ARVALID = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++)
      exp_r.push_back('{data: model_mem[(w + i) % DEPTH], last: (i == len)});
    @(posedge clk); #1;
    ARVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == stall_beat && stall_cycles > 0) begin
        RREADY = 1'b0;
        repeat (stall_cycles) @(posedge clk);
        #1;
      end
      RREADY = 1'b1;
      t = 0; @(negedge clk);
      while (!RVALID && t < 100) begin @(negedge clk); t++; end
      if (!RVALID) begin
        check("r_handshake", 128'(RVALID), 128'(1));
        break;
      end
      @(posedge clk); #1;
    end
    RREADY = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", 128'(AWREADY), 128'(0));
    check("rst_arready", 128'(ARREADY), 128'(0));
    check("rst_wready",  128'(WREADY),  128'(0));
    check("rst_bvalid",  128'(BVALID),  128'(0));
    check("rst_rvalid",  128'(RVALID),  128'(0));
    check("rst_rlast",   128'(RLAST),   128'(0));
    check("rst_bresp",   128'(BRESP),   128'(0));
    check("rst_rresp",   128'(RRESP),   128'(0));
    check("rst_rdata",   RDATA,         128'(0));
  endtask

  task automatic set_beats(input logic [127:0] base, input int len, input int wlast_at);
    for (int i = 0; i < 16; i++) begin
      wd[i] = base + 128'(i);
      ws[i] = 16'hFFFF;
      wl[i] = (i == wlast_at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, wb;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b1;

    // Four-beat write then read-back at 0x100.
    set_beats(128'hA0, 3, 3);
    write_burst(27'h100, 3);
    check("w4_bresp", 128'(b_log[b_log.size()-1]), 128'(2'b00));
    base = rd_log.size();
    read_burst(27'h100, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("r4_data", rd_log[base+i], 128'hA0 + 128'(i));
      check("r4_last", 128'(rl_log[base+i]), 128'(i == 3));
    end

    // Single-byte strobe onto a zeroed word.
    set_beats(128'h0, 0, 0);
    write_burst(27'h200, 0);
    wd[0] = {128{1'b1}}; ws[0] = 16'h0001; wl[0] = 1'b1;
    write_burst(27'h200, 0);
    base = rd_log.size();
    read_burst(27'h200, 0, 0, 0);
    check("strobe_data", rd_log[base], 128'h0000_0000_0000_0000_0000_0000_0000_00FF);
    check("len0_rlast", 128'(rl_log[base]), 128'(1));

    // Wrap from word DEPTH-1 to word 0; upper address bits and addr[3:0] ignored.
    set_beats(128'hB0, 1, 1);
    write_burst(27'h10FFF0, 1);
    base = rd_log.size();
    read_burst(27'h0FFF5, 1, 0, 0);
    read_burst(27'h0, 0, 0, 0);
    check("wrap_last_word", rd_log[base],   128'hB0);
    check("wrap_first_word", rd_log[base+1], 128'hB1);
    check("wrap_word0",     rd_log[base+2], 128'hB1);

    // Early WLAST: all four beats still accepted, SLVERR returned.
    set_beats(128'hC0, 3, 1);
    wb = w_beats;
    write_burst(27'h400, 3);
    check("early_wlast_beats", 128'(w_beats - wb), 128'(4));
    check("early_wlast_bresp", 128'(b_log[b_log.size()-1]), 128'(2'b10));
    set_beats(128'hE0, 0, 5);
    write_burst(27'h500, 0);
    check("len0_no_wlast_bresp", 128'(b_log[b_log.size()-1]), 128'(2'b10));

    // RREADY stalled 5 cycles mid-burst; model compare checks hold each cycle.
    base = rd_log.size();
    read_burst(27'h400, 3, 2, 5);
    for (int i = 0; i < 4; i++) check("stall_data", rd_log[base+i], 128'hC0 + 128'(i));

    // Reset pulsed while read beats are being presented.
    @(posedge clk); #1;
    ARADDR = 27'h100; ARLEN = 8'd3; ARVALID = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_r.push_back('{data: model_mem[16 + i], last: (i == 3)});
    @(posedge clk); #1 ARVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    exp_r.delete(); exp_b.delete(); lat_pending = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Simultaneous AW/AR twice: write, read, write, read.
    grant_log.delete();
    base = rd_log.size();
    set_beats(128'hD0, 0, 0);
    fork
      write_burst(27'h300, 0);
      read_burst(27'h100, 0, 0, 0);
    join
    wd[0] = 128'hD1;
    fork
      write_burst(27'h310, 0);
      read_burst(27'h300, 0, 0, 0);
    join
    check("grant0_write", 128'(grant_log[0]), 128'(1));
    check("grant1_read",  128'(grant_log[1]), 128'(0));
    check("grant2_write", 128'(grant_log[2]), 128'(1));
    check("grant3_read",  128'(grant_log[3]), 128'(0));
    check("post_rst_retained", rd_log[base],   128'hA0);
    check("post_rst_readback", rd_log[base+1], 128'hD0);

    repeat (3) @(posedge clk);
    check("exp_r_drained", 128'(exp_r.size()), 128'(0));
    check("exp_b_drained", 128'(exp_b.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
